rsa_job_arbiter: RTL

Shares one `rsa_rfid` modular-exponentiation core between several requesters, for example the tag-side encrypt path and the reader-side decrypt path. Each requester job has three operands: text, key and modulus. The block arbitrates among requesters round-robin, latches the winner's operands, pulses the core's `go`, and waits for `done` under a watchdog. It then returns the result, or an error, to the winning requester only.

---
 rtl/rsa_job_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation core between NREQ requesters.
// Latches the winner's operands, starts the core, waits under a watchdog and routes the result back.
module rsa_job_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_text,
  input  logic [NREQ*W-1:0] req_key,
  input  logic [NREQ*W-1:0] req_mod,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_text,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_go,
  output logic              core_rst,
  output logic [W-1:0]      core_text,
  output logic [W-1:0]      core_key,
  output logic [W-1:0]      core_mod,
  input  logic              core_done,
  input  logic [W-1:0]      core_result,
  output logic [1:0]        state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX     = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   owner, owner_d, last, last_d, grant, idx;
  logic            grant_ok;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NREQ-1:0] ack_d, rsp_valid_d, owner_bit;
  logic [W-1:0]    rsp_text_d, core_text_d, core_key_d, core_mod_d;
  logic            rsp_err_d, busy_d, core_go_d, core_rst_d;

  // First requesting index strictly after the last served owner, wrapping.
  always_comb begin
    grant    = last;
    grant_ok = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!grant_ok && req[idx]) begin
        grant    = idx;
        grant_ok = 1'b1;
      end
    end
  end

  assign owner_bit = NREQ'(1) << owner;

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    last_d      = last;
    cnt_d       = cnt;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_text_d  = rsp_text;
    rsp_err_d   = rsp_err;
    core_go_d   = 1'b0;
    core_rst_d  = 1'b0;
    core_text_d = core_text;
    core_key_d  = core_key;
    core_mod_d  = core_mod;
    unique case (state)
      S_IDLE: begin
        if (grant_ok) begin
          owner_d     = grant;
          ack_d       = NREQ'(1) << grant;
          core_text_d = req_text[int'(grant)*W +: W];
          core_key_d  = req_key[int'(grant)*W +: W];
          core_mod_d  = req_mod[int'(grant)*W +: W];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A modulus below 2 has no meaningful result; answer without touching the core.
        if (core_mod < W'(2)) begin
          rsp_valid_d = owner_bit;
          rsp_text_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          core_go_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          rsp_valid_d = owner_bit;
          rsp_text_d  = core_result;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt == TMAX) begin
          rsp_valid_d = owner_bit;
          rsp_text_d  = '0;
          rsp_err_d   = 1'b1;
          core_rst_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RESP: begin
        last_d  = owner;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= '0;
      last      <= LAST_RST;
      cnt       <= '0;
      ack       <= '0;
      rsp_valid <= '0;
      rsp_text  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      core_go   <= 1'b0;
      core_rst  <= 1'b0;
      core_text <= '0;
      core_key  <= '0;
      core_mod  <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      last      <= last_d;
      cnt       <= cnt_d;
      ack       <= ack_d;
      rsp_valid <= rsp_valid_d;
      rsp_text  <= rsp_text_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
      core_go   <= core_go_d;
      core_rst  <= core_rst_d;
      core_text <= core_text_d;
      core_key  <= core_key_d;
      core_mod  <= core_mod_d;
    end
  end

  assign state_dbg = state;

endmodule
